picoblaze_intc: RTL and testbench
=================================

PICOBLAZE_INTC -- requirements
Module: picoblaze_intc

Interface
REQ-001 Parameter BASE_ADDR, default 8'h10: PicoBlaze port_id of register offset 0; the block decodes BASE_ADDR..BASE_ADDR+3.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low; ports clk and reset_n.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 port_id  input  8  PicoBlaze port address.
REQ-006 write_strobe  input  1  one-cycle write qualifier for out_port.
REQ-007 read_strobe  input  1  one-cycle read qualifier; the block has no read side effects.
REQ-008 out_port  input  8  PicoBlaze write data.
REQ-009 in_port  output  8  registered read data.
REQ-010 irq_src  input  8  interrupt sources, for example timer_interrupt on bit 0; synchronous to clk.
REQ-011 interrupt  output  1  interrupt request to PicoBlaze.
REQ-012 interrupt_ack  input  1  one-cycle acknowledge from PicoBlaze.

Function
REQ-013 Register map offsets:
- 0 = STATUS: R = pending[7:0]; W = write-1-to-clear.
- 1 = MASK: R/W; 1 = source enabled.
- 2 = CTRL: bit0 = global enable, R/W; bit1 = EOI, write-1, self-clearing, reads 0; other bits read 0.
- 3 = VECTOR: read only; {in_service, none, 3'b0, index[2:0]}.
REQ-014 Writes at other addresses, or without write_strobe, SHALL have no effect.
REQ-015 in_port SHALL be registered each cycle from port_id, giving one-cycle latency. Unmapped addresses SHALL read 8'h00.
REQ-016 pending[i] SHALL be set by the source event defined under Configuration. Set has priority over a same-cycle W1C of the same bit.
REQ-017 Masking affects only request generation. pending SHALL latch regardless of MASK.
REQ-018 active = pending & MASK & {8{CTRL.bit0}}.
REQ-019 Priority: lowest set index of active wins. index = 3'd0 with none = 1 when active == 0.
REQ-020 FSM states IDLE, REQ, SERVICE. IDLE -> REQ when active != 0. REQ -> SERVICE on interrupt_ack. SERVICE -> IDLE on EOI write.
REQ-021 interrupt SHALL equal 1 exactly in state REQ, registered, asserting the cycle after entry into REQ.
REQ-022 In REQ, interrupt SHALL remain 1 until interrupt_ack, even if active drops to 0 through mask or W1C.
REQ-023 On interrupt_ack in REQ, the VECTOR index and none fields SHALL be captured from active in that cycle, and in_service (bit7) SHALL be set.
REQ-024 VECTOR SHALL hold the captured value through SERVICE. in_service clears on return to IDLE.
REQ-025 interrupt_ack outside REQ SHALL be ignored. An EOI write outside SERVICE SHALL be ignored.
REQ-026 EOI does not clear pending; software clears pending via STATUS W1C.
REQ-027 If active != 0 in the cycle after SERVICE -> IDLE, REQ SHALL be re-entered on the following cycle.
REQ-028 An EOI write and a new source event in the same cycle SHALL both take effect.

Reset
REQ-029 While reset_n = 0, the block SHALL force the following asynchronously:
- pending = 8'h00, MASK = 8'h00, CTRL.bit0 = 0;
- FSM = IDLE, interrupt = 0, in_port = 8'h00;
- VECTOR = 8'h40 (none = 1);
- the source-history register = 8'h00.
REQ-030 Reset asserted mid-REQ or mid-SERVICE SHALL drop interrupt in the same cycle; no request SHALL be issued until after release.
REQ-031 After reset_n deasserts, the first clk edge SHALL be a normal functional edge.

Configuration
REQ-032 Macro PICOBLAZE_INTC_EDGE_DETECT_EN.
REQ-033 When PICOBLAZE_INTC_EDGE_DETECT_EN is defined:
- pending[i] is set on the rising edge of irq_src[i] (current = 1, previous registered = 0);
- a held-high source sets pending only once.
REQ-034 When PICOBLAZE_INTC_EDGE_DETECT_EN is undefined:
- level mode; pending[i] is set every cycle irq_src[i] = 1;
- W1C of a still-high source has no lasting effect;
- the history register is absent.

Verification
REQ-035 The bench SHALL cover these scenarios:
- MASK = 01, CTRL = 01, pulse irq_src[0] -> interrupt = 1 two cycles after the pulse; ack -> interrupt = 0 next cycle; VECTOR reads 8'h80.
- Edge mode: irq_src = 8'h24 simultaneously, MASK = FF, enabled -> ack; VECTOR = 8'h82; W1C 04 plus EOI -> REQ re-entered; second ack gives VECTOR = 8'h85.
- In REQ, write MASK = 00 before ack -> interrupt stays 1; ack -> VECTOR = 8'hC0 (in_service, none).
- Edge mode: W1C bit 3 in the same cycle as a rising irq_src[3] -> STATUS reads 8'h08.
- Assert reset_n = 0 while in SERVICE -> interrupt = 0, STATUS = 00, MASK = 00, VECTOR = 8'h40 immediately.
- Read port_id = BASE_ADDR+5 -> in_port = 00; write to unmapped addresses -> no register changes.

Source files
------------

// File: rtl/picoblaze_intc_if.sv
// PicoBlaze I/O port bus plus interrupt handshake, shared by the
// processor side (master) and the interrupt controller (slave).
interface picoblaze_intc_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/picoblaze_intc.sv
// PicoBlaze interrupt controller: 8 sources, STATUS/MASK/CTRL/VECTOR
// registers at BASE_ADDR..BASE_ADDR+3, lowest-index priority, and an
// IDLE/REQ/SERVICE handshake with interrupt_ack and an EOI write.
// Optional feature macro: PICOBLAZE_INTC_EDGE_DETECT_EN selects rising-edge
// source detection; when undefined, sources are level sensitive.
module picoblaze_intc #(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        irq_src,
  picoblaze_intc_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic       en_q, en_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] rdata_q, rdata_d;
  logic       irq_q, irq_d;

  logic [7:0] off;
  logic       hit;
  logic       wr_status, wr_mask, wr_ctrl, eoi;
  logic [7:0] set_v;
  logic [7:0] active;
  logic [2:0] idx;
  logic       none;
  logic       unused_read;

  // Reads have no side effects, so read_strobe carries no function here.
  assign unused_read = bus.read_strobe;

  assign off       = bus.port_id - BASE_ADDR;
  assign hit       = (off[7:2] == 6'd0);
  assign wr_status = bus.write_strobe & hit & (off[1:0] == 2'd0);
  assign wr_mask   = bus.write_strobe & hit & (off[1:0] == 2'd1);
  assign wr_ctrl   = bus.write_strobe & hit & (off[1:0] == 2'd2);
  assign eoi       = wr_ctrl & bus.out_port[1];

`ifdef PICOBLAZE_INTC_EDGE_DETECT_EN
  logic [7:0] hist_q;

  // Source history for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_q <= '0;
    else          hist_q <= irq_src;
  end

  assign set_v = irq_src & ~hist_q;
`else
  assign set_v = irq_src;
`endif

  // Register next-state: W1C on STATUS with source set taking priority.
  always_comb begin
    pending_d = (pending_q & ~(wr_status ? bus.out_port : 8'h00)) | set_v;
    mask_d    = wr_mask ? bus.out_port : mask_q;
    en_d      = wr_ctrl ? bus.out_port[0] : en_q;
  end

  // Lowest set index of active wins; none flags an empty active set.
  always_comb begin
    active = pending_q & mask_q & {8{en_q}};
    idx    = 3'd0;
    none   = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (none && active[i]) begin
        idx  = 3'(i);
        none = 1'b0;
      end
    end
  end

  // Handshake FSM next state, VECTOR capture and registered interrupt.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE:    if (active != 8'h00) state_d = REQ;
      REQ:     if (bus.interrupt_ack) begin
                 state_d = SERVICE;
                 vec_d   = {1'b1, none, 3'b000, idx};
               end
      SERVICE: if (eoi) begin
                 state_d  = IDLE;
                 vec_d[7] = 1'b0;
               end
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == REQ);
  end

  // Registered read mux; unmapped addresses read zero.
  always_comb begin
    rdata_d = 8'h00;
    if (hit) begin
      case (off[1:0])
        2'd0:    rdata_d = pending_q;
        2'd1:    rdata_d = mask_q;
        2'd2:    rdata_d = {7'b0, en_q};
        default: rdata_d = vec_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      en_q      <= 1'b0;
      vec_q     <= 8'h40;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      en_q      <= en_d;
      vec_q     <= vec_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.in_port   = rdata_q;
  assign bus.interrupt = irq_q;

endmodule

// File: tb/tb_picoblaze_intc.sv
// Directed bench for picoblaze_intc at BASE_ADDR = 8'h10.
module tb_picoblaze_intc;

  localparam logic [7:0] BASE = 8'h10;
  localparam logic [7:0] A_STATUS = BASE;
  localparam logic [7:0] A_MASK   = BASE + 8'd1;
  localparam logic [7:0] A_CTRL   = BASE + 8'd2;
  localparam logic [7:0] A_VECTOR = BASE + 8'd3;

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_src;
  int         checks;
  int         failures;
  logic [7:0] rv;

  picoblaze_intc_if bus ();

  picoblaze_intc #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.port_id      = addr;
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
    bus.port_id      = 8'h00;
    bus.out_port     = 8'h00;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] data);
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    tick();
    data            = bus.in_port;
    bus.read_strobe = 1'b0;
    bus.port_id     = 8'h00;
  endtask

  task automatic ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] src);
    irq_src = src;
    tick();
    irq_src = 8'h00;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    irq_src  = 8'h00;
    bus.port_id       = 8'h00;
    bus.out_port      = 8'h00;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.interrupt_ack = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_irq", {7'b0, bus.interrupt}, 8'h00);
    check("rst_inport", bus.in_port, 8'h00);
    #3 reset_n = 1'b1;
    tick();
    rd(A_STATUS, rv); check("rst_status", rv, 8'h00);
    rd(A_MASK, rv);   check("rst_mask", rv, 8'h00);
    rd(A_CTRL, rv);   check("rst_ctrl", rv, 8'h00);
    rd(A_VECTOR, rv); check("rst_vector", rv, 8'h40);

    // Unmapped reads/writes and writes without strobe
    rd(BASE + 8'd5, rv); check("unmapped_rd", rv, 8'h00);
    wr(BASE + 8'd5, 8'hFF);
    wr(BASE + 8'd4, 8'hFF);
    wr(BASE - 8'd1, 8'hFF);
    bus.port_id  = A_MASK;
    bus.out_port = 8'hFF;
    tick();
    bus.port_id  = 8'h00;
    bus.out_port = 8'h00;
    rd(A_MASK, rv); check("nowr_mask", rv, 8'h00);
    rd(A_CTRL, rv); check("nowr_ctrl", rv, 8'h00);

    // Basic request/ack on source 0
    wr(A_MASK, 8'h01);
    wr(A_CTRL, 8'h01);
    pulse(8'h01);
    check("s1_irq_1cyc", {7'b0, bus.interrupt}, 8'h00);
    tick();
    check("s1_irq_2cyc", {7'b0, bus.interrupt}, 8'h01);
    ack();
    check("s1_irq_after_ack", {7'b0, bus.interrupt}, 8'h00);
    rd(A_VECTOR, rv); check("s1_vector", rv, 8'h80);
    rd(A_STATUS, rv); check("s1_status", rv, 8'h01);
    wr(A_STATUS, 8'h01);
    wr(A_CTRL, 8'h03);
    tick(); tick();
    check("s1_idle_irq", {7'b0, bus.interrupt}, 8'h00);
    rd(A_CTRL, rv); check("s1_ctrl_eoi_reads0", rv, 8'h01);

    // Mask drop in REQ keeps interrupt; EOI outside SERVICE ignored
    pulse(8'h01);
    tick();
    check("s2_irq", {7'b0, bus.interrupt}, 8'h01);
    wr(A_MASK, 8'h00);
    check("s2_irq_masked", {7'b0, bus.interrupt}, 8'h01);
    wr(A_CTRL, 8'h03);
    check("s2_eoi_in_req", {7'b0, bus.interrupt}, 8'h01);
    ack();
    check("s2_irq_ack", {7'b0, bus.interrupt}, 8'h00);
    rd(A_VECTOR, rv); check("s2_vector", rv, 8'hC0);
    wr(A_STATUS, 8'h01);
    wr(A_CTRL, 8'h03);
    tick(); tick();
    check("s2_idle_irq", {7'b0, bus.interrupt}, 8'h00);

    // Source set wins over same-cycle W1C of that bit
    irq_src          = 8'h08;
    bus.port_id      = A_STATUS;
    bus.out_port     = 8'h08;
    bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
    irq_src          = 8'h00;
    rd(A_STATUS, rv); check("set_vs_w1c", rv, 8'h08);
    wr(A_STATUS, 8'h08);
    rd(A_STATUS, rv); check("w1c_clear", rv, 8'h00);

    // Held-high source behaviour
    irq_src = 8'h10;
    tick();
    wr(A_STATUS, 8'h10);
`ifdef PICOBLAZE_INTC_EDGE_DETECT_EN
    rd(A_STATUS, rv); check("edge_hold_once", rv, 8'h00);
    irq_src = 8'h00;
`else
    rd(A_STATUS, rv); check("level_w1c_held", rv, 8'h10);
    irq_src = 8'h00;
    wr(A_STATUS, 8'h10);
    rd(A_STATUS, rv); check("level_w1c_low", rv, 8'h00);
`endif

    // Priority, W1C + EOI, re-entry into REQ
    wr(A_MASK, 8'hFF);
    pulse(8'h24);
    tick();
    check("s3_irq", {7'b0, bus.interrupt}, 8'h01);
    ack();
    rd(A_VECTOR, rv); check("s3_vector1", rv, 8'h82);
    wr(A_STATUS, 8'h04);
    wr(A_CTRL, 8'h03);
    check("s3_idle_after_eoi", {7'b0, bus.interrupt}, 8'h00);
    tick();
    check("s3_reenter", {7'b0, bus.interrupt}, 8'h01);
    ack();
    rd(A_VECTOR, rv); check("s3_vector2", rv, 8'h85);
    wr(A_STATUS, 8'h20);
    wr(A_CTRL, 8'h03);
    tick(); tick();
    check("s3_idle_irq", {7'b0, bus.interrupt}, 8'h00);

    // Ack outside REQ ignored
    ack();
    check("stray_ack_irq", {7'b0, bus.interrupt}, 8'h00);
    rd(A_VECTOR, rv); check("stray_ack_insvc", {7'b0, rv[7]}, 8'h00);

    // Reset while in SERVICE
    pulse(8'h02);
    tick();
    check("s4_irq", {7'b0, bus.interrupt}, 8'h01);
    ack();
    rd(A_VECTOR, rv); check("s4_vector", rv, 8'h81);
    bus.port_id = A_MASK;
    #2 reset_n = 1'b0;
    #1;
    check("s4_rst_irq", {7'b0, bus.interrupt}, 8'h00);
    check("s4_rst_inport", bus.in_port, 8'h00);
    tick();
    check("s4_rst_inport_hold", bus.in_port, 8'h00);
    #3 reset_n = 1'b1;
    tick();
    rd(A_STATUS, rv); check("s4_status", rv, 8'h00);
    rd(A_MASK, rv);   check("s4_mask", rv, 8'h00);
    rd(A_CTRL, rv);   check("s4_ctrl", rv, 8'h00);
    rd(A_VECTOR, rv); check("s4_vector_rst", rv, 8'h40);
    tick(); tick();
    check("s4_irq_after", {7'b0, bus.interrupt}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
